// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode,
// memory, ALU and branch steps, with a memory-wait watchdog and sticky trap causes.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  if (TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must not exceed 255");
  end

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       illegal_q, bus_err_q;
  logic       set_illegal, set_bus_err;
  logic       timed_out;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) && !mem_ready;

  // Counter is only observed in memory-wait states; clearing on every state
  // change is equivalent to clearing on entry to those states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else if (timed_out) begin
          state_d     = TRAP;
          set_bus_err = 1'b1;
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BEQ;
          default: begin
            state_d     = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (op == OP_LOAD) state_d = MEMREAD;
        else if (op == OP_STORE) state_d = MEMWRITE;
        else begin
          state_d     = TRAP;
          set_illegal = 1'b1;
        end
      end
      MEMREAD, MEMWRITE: begin
        if (mem_ready) state_d = (state_q == MEMREAD) ? MEMWB : FETCH;
        else if (timed_out) begin
          state_d     = TRAP;
          set_bus_err = 1'b1;
        end
      end
      MEMWB, ALUWB, BEQ: state_d = FETCH;
      EXECR, EXECI:      state_d = ALUWB;
      TRAP:              state_d = TRAP;
      default: begin
        state_d     = TRAP;
        set_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready && !reset) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      default:   imm_src = 2'b00;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table for the main
// instruction flows plus hand sequences for trap, watchdog and reset corners.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] op;

  logic       mem_req, mem_we, pc_write, ir_write, reg_write, adr_src, illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [3:0] state;

  logic       mem_req_4, mem_we_4, pc_write_4, ir_write_4, reg_write_4, adr_src_4, illegal_4, bus_err_4;
  logic [1:0] alu_src_a_4, alu_src_b_4, alu_op_4, result_src_4, imm_src_4;
  logic [3:0] state_4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  multicycle_control #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_4), .mem_we(mem_we_4), .pc_write(pc_write_4), .ir_write(ir_write_4),
    .reg_write(reg_write_4), .adr_src(adr_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
    .alu_op(alu_op_4), .result_src(result_src_4), .imm_src(imm_src_4), .illegal(illegal_4),
    .bus_err(bus_err_4), .state(state_4)
  );

  typedef struct {
    logic [6:0] op;
    logic       zero;
    logic       mr;
    logic [3:0] st;
    logic       req, we, pcw, irw, rw, adr;
    logic [1:0] a, b, alu, res, imm;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    #2;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // lw with two wait cycles in FETCH and MEMREAD
    vecs[0]  = '{7'h03, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    vecs[1]  = '{7'h03, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    vecs[2]  = '{7'h03, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    vecs[3]  = '{7'h03, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{7'h03, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{7'h03, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{7'h03, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{7'h03, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{7'h03, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    // sw with immediate mem_ready
    vecs[9]  = '{7'h23, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
    vecs[10] = '{7'h23, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    vecs[11] = '{7'h23, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    vecs[12] = '{7'h23, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    // beq taken
    vecs[13] = '{7'h63, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10};
    vecs[14] = '{7'h63, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    vecs[15] = '{7'h63, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    // beq not taken
    vecs[16] = '{7'h63, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10};
    vecs[17] = '{7'h63, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    vecs[18] = '{7'h63, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    // R-type
    vecs[19] = '{7'h33, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    vecs[20] = '{7'h33, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[21] = '{7'h33, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    vecs[22] = '{7'h33, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    // I-type
    vecs[23] = '{7'h13, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    vecs[24] = '{7'h13, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[25] = '{7'h13, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    vecs[26] = '{7'h13, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[27] = '{7'h13, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};

    // Reset state, with mem_ready high to show fetch enables are gated
    reset     = 1'b1;
    op        = 7'h03;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_fetch_en", 32'({ir_write, pc_write}), 32'd0);
    chk("rst_traps", 32'({illegal, bus_err, illegal_4, bus_err_4}), 32'd0);
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      op        = vecs[i].op;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          32'({state, mem_req, mem_we, pc_write, ir_write, reg_write, adr_src,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal, bus_err}),
          32'({vecs[i].st, vecs[i].req, vecs[i].we, vecs[i].pcw, vecs[i].irw, vecs[i].rw,
               vecs[i].adr, vecs[i].a, vecs[i].b, vecs[i].alu, vecs[i].res, vecs[i].imm, 2'b00}));
      tick();
    end

    // Illegal opcode: DECODE -> TRAP, held with no memory activity
    do_reset();
    op        = 7'h7F;
    zero      = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ill_fetch_irw", 32'({state, ir_write}), 32'h01);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ill_decode", 32'(state), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      @(negedge clk);
      chk($sformatf("ill_trap%0d", i),
          32'({state, illegal, bus_err, mem_req, mem_we, pc_write, ir_write, reg_write}),
          32'({4'd10, 1'b1, 1'b0, 5'b00000}));
      tick();
    end
    reset = 1'b1;
    #2;
    chk("ill_reset", 32'({state, illegal}), 32'h00);
    tick();
    reset = 1'b0;

    // Watchdog: TIMEOUT=4 traps after 4 FETCH cycles; default 16 keeps waiting
    op        = 7'h13;
    zero      = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("to4_fetch%0d", i), 32'(state_4), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to4_trap", 32'({state_4, bus_err_4, illegal_4, mem_req_4}), 32'({4'd10, 3'b100}));
    chk("to16_still_fetch", 32'({state, bus_err}), 32'h00);
    for (int i = 0; i < 11; i++) tick();
    @(negedge clk);
    chk("to16_last_fetch", 32'({state, bus_err}), 32'h00);
    tick();
    @(negedge clk);
    chk("to16_trap", 32'({state, bus_err}), 32'({4'd10, 1'b1}));

    // mem_ready on the final allowed cycle beats the timeout
    do_reset();
    op = 7'h13;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("to4_ready_irw", 32'({state_4, ir_write_4}), 32'h01);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("to4_ready_decode", 32'({state_4, bus_err_4}), 32'({4'd1, 1'b0}));

    // Reset mid-MEMREAD abandons the access, then a normal fetch
    do_reset();
    op        = 7'h03;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mr_in_memread", 32'({state, mem_req, adr_src}), 32'({4'd3, 2'b11}));
    #2;
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("mr_async_reset", 32'({state, ir_write, pc_write, mem_req, adr_src}), 32'({4'd0, 4'b0010}));
    tick();
    chk("mr_reset_held", 32'({state, ir_write}), 32'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_refetch_irw", 32'({state, ir_write, pc_write}), 32'({4'd0, 2'b11}));
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mr_refetch_decode", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: memory-wait watchdog limit in cycles; 0 disables the watchdog.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port op, input, 7 bits: instr[6:0] from the instruction register, stable except in the cycle after ir_write.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completes the current access in this cycle.
REQ-008 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-009 SHALL have port mem_we, output, 1 bit: write qualifier for mem_req.
REQ-010 SHALL have ports pc_write, ir_write and reg_write, each output, 1 bit: register enables.
REQ-011 SHALL have port adr_src, output, 1 bit: memory address select; 0 selects PC, 1 selects ALUOut.
REQ-012 SHALL have ports alu_src_a and alu_src_b, each output, 2 bits.
- alu_src_a: 00 PC, 01 oldPC, 10 rs1.
- alu_src_b: 00 rs2, 01 imm32, 10 constant 4.
REQ-013 SHALL have ports alu_op, result_src and imm_src, each output, 2 bits.
- alu_op: 00 add, 01 sub, 10 funct-decoded.
- result_src: 00 ALUOut, 01 read data, 10 ALU result.
- imm_src: 00 I, 01 S, 10 B.
REQ-014 SHALL have ports illegal and bus_err, each output, 1 bit: sticky trap causes.
REQ-015 SHALL have port state, output, 4 bits: current state encoding.

Function
REQ-016 SHALL implement a Moore FSM with this encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, TRAP=10; unused codes SHALL go to TRAP with illegal=1.
REQ-017 SHALL drive imm_src combinationally from op in every state: 0x23 gives 01, 0x63 gives 10, all other opcodes give 00.
REQ-018 SHALL drive every output not listed for a state as 0.
REQ-019 SHALL behave in FETCH as follows:
- mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
- ir_write=1 and pc_write=1 only in the cycle mem_ready=1; next state DECODE.
- Otherwise remain in FETCH.
REQ-020 SHALL behave in DECODE (1 cycle) as follows:
- alu_src_a=01, alu_src_b=01, alu_op=00, which computes the branch target.
- Next state by op: 0x03 or 0x23 go to MEMADR; 0x33 goes to EXECR; 0x13 goes to EXECI; 0x63 goes to BEQ; any other opcode goes to TRAP with illegal set.
REQ-021 SHALL behave in MEMADR as follows: alu_src_a=10, alu_src_b=01, alu_op=00; next state MEMREAD if op=0x03, MEMWRITE if op=0x23.
REQ-022 SHALL behave in MEMREAD as follows: mem_req=1, adr_src=1, result_src=00; go to MEMWB on mem_ready, otherwise wait.
REQ-023 SHALL behave in MEMWB as follows: result_src=01, reg_write=1; next state FETCH.
REQ-024 SHALL behave in MEMWRITE as follows: mem_req=1, mem_we=1, adr_src=1, result_src=00; go to FETCH on mem_ready, otherwise wait.
REQ-025 SHALL behave in EXECR and EXECI as follows: alu_src_a=10, alu_op=10; alu_src_b=00 in EXECR and 01 in EXECI; next state ALUWB.
REQ-026 SHALL behave in ALUWB as follows: result_src=00, reg_write=1; next state FETCH.
REQ-027 SHALL behave in BEQ as follows: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write equals zero; next state FETCH.
REQ-028 SHALL, in TRAP, hold every enable and mem_req at 0, hold illegal and bus_err at their latched values, and leave TRAP only on reset.
REQ-029 SHALL implement the watchdog as follows:
- An 8-bit wait counter clears on entry to FETCH, MEMREAD or MEMWRITE.
- It increments each cycle in those states while mem_req=1 and mem_ready=0.
- If TIMEOUT≠0, counter=TIMEOUT-1 and mem_ready=0, the next state is TRAP with bus_err=1.
REQ-030 SHALL let mem_ready win over the timeout when both occur in the same cycle.
REQ-031 SHALL require TIMEOUT ≤ 255.
REQ-032 SHALL never assert mem_req together with reg_write, and SHALL never assert ir_write outside FETCH.

Reset
REQ-033 SHALL, while reset=1, force state=FETCH, the wait counter to 0 and illegal=bus_err=0, with effect regardless of clk.
REQ-034 SHALL drive the FETCH Moore outputs during reset (mem_req=1), while ir_write and pc_write are gated to 0 until reset deasserts.
REQ-035 SHALL treat reset asserted mid-access (any state) as abandoning the access; the first post-reset cycle is FETCH.

Verification
REQ-036 SHALL pass these directed scenarios:
- lw (op=0x03), mem_ready high after 2 wait cycles in each memory state → state sequence 0,0,0,1,2,3,3,3,4,0; reg_write=1 only in MEMWB with result_src=01.
- sw (op=0x23), mem_ready immediate → 0,1,2,5,0; mem_we=1 only in state 5; imm_src=01 throughout.
- beq (op=0x63) with zero=1, then again with zero=0 → pc_write=1 in BEQ in the first run and 0 in the second; imm_src=10.
- op=0x7F after fetch → DECODE→TRAP; illegal=1 held for 10 cycles with no mem_req; reset returns to FETCH with illegal=0.
- TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after exactly 4 FETCH cycles with bus_err=1; a repeat with mem_ready on the 4th cycle → DECODE and no bus_err.
- reset asserted mid-cycle in MEMREAD → state=0 immediately, ir_write=0, then a normal fetch completes.
